dds_serial_writer: RTL and testbench



---
 rtl/dds_serial_writer.sv | 221 ++++++++++++++++++++++
 tb/tb_dds_serial_writer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_serial_writer.sv
`timescale 1ns/1ps
// dds_serial_writer
//
// Replays an assembled NBITS-bit DDS programming word onto the DDS serial port,
// entirely on the system clock. A toggle on new_word_tgl (from the Rabbit SCLK
// domain) is synchronised, the word is snapshotted, then shifted out index 0
// first: chip-select low, NBITS serial clocks, chip-select high, IO_UPDATE pulse.
//
// Ports:
//   clk            system clock, the only clock
//   rst_n          synchronous active-low reset
//   full_word      assembled word, bit 0 is sent first
//   new_word_tgl   asynchronous toggle, one change per completed upstream word
//   dds_cs_n       DDS chip select, active low
//   dds_sclk       DDS serial clock, idles low, DDS samples on rising edge
//   dds_sdio       DDS serial data, changes on falling edges of dds_sclk
//   dds_io_update  DDS register-commit pulse, UPD_CYCLES clocks wide
//   busy           high from frame start until return to idle
//   overrun        sticky, set when a request had to be merged and was lost
//   frame_count    completed frames, wraps
module dds_serial_writer #(
    parameter int unsigned NBITS      = 184,
    parameter int unsigned HALF_DIV   = 4,
    parameter int unsigned UPD_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NBITS-1:0] full_word,
    input  logic             new_word_tgl,
    output logic             dds_cs_n,
    output logic             dds_sclk,
    output logic             dds_sdio,
    output logic             dds_io_update,
    output logic             busy,
    output logic             overrun,
    output logic [15:0]      frame_count
);

    localparam int unsigned CntMax = (HALF_DIV > UPD_CYCLES) ? HALF_DIV : UPD_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned BitW   = $clog2(NBITS + 1);

    localparam logic [CntW-1:0] HalfLast = CntW'(HALF_DIV - 1);
    localparam logic [CntW-1:0] UpdLast  = CntW'(UPD_CYCLES - 1);
    localparam logic [BitW-1:0] LastBit  = BitW'(NBITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StUpdate
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [NBITS-1:0]   sreg_q, sreg_d;
    logic               cs_n_q, cs_n_d;
    logic               sclk_q, sclk_d;
    logic               sdio_q, sdio_d;
    logic               io_update_q, io_update_d;
    logic               busy_q, busy_d;
    logic               pending_q, pending_d;
    logic               overrun_q, overrun_d;
    logic [15:0]        frame_count_q, frame_count_d;

    // Toggle synchroniser. Deliberately not reset: it keeps tracking the input
    // through reset so a level held across reset never looks like a toggle.
    logic sync1_q, sync2_q, sync3_q;
    logic req;

    always_ff @(posedge clk) begin
        sync1_q <= new_word_tgl;
        sync2_q <= sync1_q;
        sync3_q <= sync2_q;
    end

    assign req = (sync2_q ^ sync3_q) & rst_n;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_cnt_d     = bit_cnt_q;
        sreg_d        = sreg_q;
        cs_n_d        = cs_n_q;
        sclk_d        = sclk_q;
        sdio_d        = sdio_q;
        io_update_d   = io_update_q;
        busy_d        = busy_q;
        pending_d     = pending_q;
        overrun_d     = overrun_q;
        frame_count_d = frame_count_q;

        // Requests outside idle are queued (one deep); a second one is merged.
        if (req) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end
            if (state_q != StIdle) begin
                pending_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (req || pending_q) begin
                    sreg_d    = full_word;
                    sdio_d    = full_word[0];
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    pending_d = 1'b0;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = StSetup;
                end
            end

            // Data setup time before the first rising edge.
            StSetup: begin
                if (cnt_q == HalfLast) begin
                    sclk_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = StShift;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // bit_cnt counts falling edges; the NBITS-th fall ends the shift.
            StShift: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_cnt_q == LastBit) begin
                            state_d = StHold;
                        end else begin
                            sdio_d    = sreg_q[1];
                            sreg_d    = sreg_q >> 1;
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Hold time after the last falling edge before releasing chip select.
            StHold: begin
                if (cnt_q == HalfLast) begin
                    cs_n_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = StUpdate;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // One clock of gap after cs_n rises, then the io_update pulse.
            StUpdate: begin
                if (!io_update_q) begin
                    io_update_d = 1'b1;
                    cnt_d       = '0;
                end else if (cnt_q == UpdLast) begin
                    io_update_d   = 1'b0;
                    frame_count_d = frame_count_q + 16'd1;
                    busy_d        = 1'b0;
                    state_d       = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            bit_cnt_q     <= '0;
            sreg_q        <= '0;
            cs_n_q        <= 1'b1;
            sclk_q        <= 1'b0;
            sdio_q        <= 1'b0;
            io_update_q   <= 1'b0;
            busy_q        <= 1'b0;
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            sreg_q        <= sreg_d;
            cs_n_q        <= cs_n_d;
            sclk_q        <= sclk_d;
            sdio_q        <= sdio_d;
            io_update_q   <= io_update_d;
            busy_q        <= busy_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign dds_cs_n      = cs_n_q;
    assign dds_sclk      = sclk_q;
    assign dds_sdio      = sdio_q;
    assign dds_io_update = io_update_q;
    assign busy          = busy_q;
    assign overrun       = overrun_q;
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_dds_serial_writer.sv
`timescale 1ns/1ps
// Bench for dds_serial_writer. Two instances share the stimulus: one at default
// timing, one at HALF_DIV=1/UPD_CYCLES=1. Each is checked every cycle against a
// frame-offset model, plus an edge monitor that rebuilds the shifted word.
module tb_dds_serial_writer;

    localparam int N  = 184;
    localparam int H0 = 4;
    localparam int U0 = 8;
    localparam int H1 = 1;
    localparam int U1 = 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   full_word = '0;
    logic           tgl = 1'b1;

    logic           cs_n_w [2];
    logic           sclk_w [2];
    logic           sdio_w [2];
    logic           io_w   [2];
    logic           busy_w [2];
    logic           ov_w   [2];
    logic [15:0]    fc_w   [2];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always #5 clk = ~clk;

    dds_serial_writer #(.NBITS(N), .HALF_DIV(H0), .UPD_CYCLES(U0)) dut (
        .clk(clk), .rst_n(rst_n), .full_word(full_word), .new_word_tgl(tgl),
        .dds_cs_n(cs_n_w[0]), .dds_sclk(sclk_w[0]), .dds_sdio(sdio_w[0]),
        .dds_io_update(io_w[0]), .busy(busy_w[0]), .overrun(ov_w[0]),
        .frame_count(fc_w[0])
    );

    dds_serial_writer #(.NBITS(N), .HALF_DIV(H1), .UPD_CYCLES(U1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .full_word(full_word), .new_word_tgl(tgl),
        .dds_cs_n(cs_n_w[1]), .dds_sclk(sclk_w[1]), .dds_sdio(sdio_w[1]),
        .dds_io_update(io_w[1]), .busy(busy_w[1]), .overrun(ov_w[1]),
        .frame_count(fc_w[1])
    );

    // ---------------- reference model ----------------
    // k_m = cycles since the frame-start edge (1 = first cs_n-low cycle), 0 = idle.
    int           k_m      [2] = '{0, 0};
    logic [N-1:0] word_m   [2];
    bit           pend_m   [2] = '{0, 0};
    bit           ov_m     [2] = '{0, 0};
    logic [15:0]  fc_m     [2] = '{16'd0, 16'd0};
    logic         hold_m   [2] = '{1'b0, 1'b0};
    logic         h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

    function automatic int hdiv(input int d);
        return (d == 0) ? H0 : H1;
    endfunction

    function automatic int ucyc(input int d);
        return (d == 0) ? U0 : U1;
    endfunction

    function automatic int frame_len(input int d);
        return (2 * N + 1) * hdiv(d) + 1 + ucyc(d);
    endfunction

    task automatic model_step(input int d, input bit req);
        if (!rst_n) begin
            k_m[d] = 0; pend_m[d] = 0; ov_m[d] = 0; fc_m[d] = 16'd0; hold_m[d] = 1'b0;
        end else if (k_m[d] != 0) begin
            if (req) begin
                if (pend_m[d]) ov_m[d] = 1;
                pend_m[d] = 1;
            end
            if (k_m[d] == frame_len(d)) begin
                fc_m[d]   = fc_m[d] + 16'd1;
                hold_m[d] = word_m[d][N-1];
                k_m[d]    = 0;
            end else begin
                k_m[d] = k_m[d] + 1;
            end
        end else if (req || pend_m[d]) begin
            if (req && pend_m[d]) ov_m[d] = 1;
            word_m[d] = full_word;
            pend_m[d] = 0;
            k_m[d]    = 1;
        end
    endtask

    // {cs_n, sclk, sdio, io_update, busy}
    function automatic logic [4:0] model_out(input int d);
        int k, h, lcs, p, b;
        k   = k_m[d];
        h   = hdiv(d);
        lcs = (2 * N + 1) * h;
        if (k == 0) return {1'b1, 1'b0, hold_m[d], 1'b0, 1'b0};
        if (k <= lcs) begin
            p = (k - 1) / h;
            b = p / 2;
            if (b > N - 1) b = N - 1;
            return {1'b0, p[0], word_m[d][b], 1'b0, 1'b1};
        end
        if (k == lcs + 1) return {1'b1, 1'b0, word_m[d][N-1], 1'b0, 1'b1};
        return {1'b1, 1'b0, word_m[d][N-1], 1'b1, 1'b1};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- edge monitor ----------------
    logic         prev_cs   [2] = '{1'b1, 1'b1};
    logic         prev_sclk [2] = '{1'b0, 1'b0};
    logic         prev_io   [2] = '{1'b0, 1'b0};
    int           cs_cnt [2], hi_cnt [2], last_cs_low [2], last_hi_gap [2];
    int           rises [2], last_rises [2], io_cnt [2], last_io_len [2], io_total [2];
    int           gmin [2], gmax [2], last_gmin [2], last_gmax [2], last_rise_cyc [2];
    logic [N-1:0] cap [2], last_cap [2];

    task automatic monitor(input int d);
        logic cs, sc, io;
        int   g;
        cs = cs_n_w[d]; sc = sclk_w[d]; io = io_w[d];
        if (prev_cs[d] && !cs) begin
            last_hi_gap[d] = hi_cnt[d];
            cs_cnt[d] = 1; rises[d] = 0; cap[d] = '0;
            gmin[d] = 1 << 30; gmax[d] = 0; last_rise_cyc[d] = -1;
        end else if (!cs) begin
            cs_cnt[d]++;
        end
        if (!prev_cs[d] && cs) begin
            last_cs_low[d] = cs_cnt[d]; last_rises[d] = rises[d]; last_cap[d] = cap[d];
            last_gmin[d] = gmin[d]; last_gmax[d] = gmax[d]; hi_cnt[d] = 1;
        end else if (cs) begin
            hi_cnt[d]++;
        end
        if (!prev_sclk[d] && sc) begin
            if (rises[d] < N) cap[d][rises[d]] = sdio_w[d];
            rises[d]++;
            if (last_rise_cyc[d] >= 0) begin
                g = cyc - last_rise_cyc[d];
                if (g < gmin[d]) gmin[d] = g;
                if (g > gmax[d]) gmax[d] = g;
            end
            last_rise_cyc[d] = cyc;
        end
        if (io) io_cnt[d]++;
        if (!prev_io[d] && io) io_total[d]++;
        if (prev_io[d] && !io) begin
            last_io_len[d] = io_cnt[d];
            io_cnt[d] = 0;
        end
        prev_cs[d] = cs; prev_sclk[d] = sc; prev_io[d] = io;
    endtask

    // ---------------- compare process ----------------
    initial begin : compare_proc
        bit req;
        for (int d = 0; d < 2; d++) begin
            cs_cnt[d] = 0; hi_cnt[d] = 0; last_cs_low[d] = 0; last_hi_gap[d] = 0;
            rises[d] = 0; last_rises[d] = 0; io_cnt[d] = 0; last_io_len[d] = 0;
            io_total[d] = 0; gmin[d] = 0; gmax[d] = 0; last_gmin[d] = 0; last_gmax[d] = 0;
            last_rise_cyc[d] = -1; cap[d] = '0; last_cap[d] = '0; word_m[d] = '0;
        end
        forever begin
            @(posedge clk);
            #1;
            // A toggle reaches the state machine on the third edge after it changes.
            req = rst_n && (h2 ^ h3);
            h3 = h2; h2 = h1; h1 = tgl;
            for (int d = 0; d < 2; d++) begin
                model_step(d, req);
                check($sformatf("cycle_outputs_dut%0d", d),
                      {cs_n_w[d], sclk_w[d], sdio_w[d], io_w[d], busy_w[d], ov_w[d], fc_w[d]},
                      {model_out(d), ov_m[d], fc_m[d]});
                monitor(d);
            end
            cyc++;
            if (mismatched >= 50) begin
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
                $finish;
            end
        end
    end

    initial begin : watchdog
        #900000;
        mismatched++;
        $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic toggle();
        @(negedge clk);
        tgl = ~tgl;
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int q = 0;
        int n = 0;
        while (q < 8 && n < budget) begin
            @(negedge clk);
            n++;
            if (!busy_w[0] && !busy_w[1]) q++;
            else q = 0;
        end
        check({name, "_idle_reached"}, (q >= 8), 1'b1);
    endtask

    initial begin : stimulus
        logic [N-1:0]  w_a5, w_alt, w_one, w_save;
        logic [191:0]  tmp;
        int            io_before, n;
        logic [15:0]   fc_prev;

        for (int i = 0; i < N / 8; i++) w_a5[i*8 +: 8] = 8'hA5;
        for (int i = 0; i < N; i++) w_alt[i] = ~i[0];
        w_one = '0;
        w_one[0] = 1'b1;

        // Reset with the toggle held high: no request may come out of it.
        tick(5);
        rst_n = 1'b1;
        tick(100);
        check("reset_outputs_dut0",
              {cs_n_w[0], sclk_w[0], sdio_w[0], io_w[0], busy_w[0], ov_w[0]}, 6'b100000);
        check("reset_frame_count_dut0", fc_w[0], 16'd0);
        check("reset_frame_count_dut1", fc_w[1], 16'd0);

        // Single A5 frame.
        full_word = w_a5;
        toggle();
        wait_quiet("a5", 3000);
        check("a5_rises", last_rises[0], 184);
        check("a5_bits", last_cap[0], w_a5);
        check("a5_cs_low", last_cs_low[0], 1476);
        check("a5_io_len", last_io_len[0], 8);
        check("a5_frame_count", fc_w[0], 16'd1);
        check("a5_busy", busy_w[0], 1'b0);
        check("a5_fast_cs_low", last_cs_low[1], 369);
        check("a5_fast_io_len", last_io_len[1], 1);
        check("a5_fast_bits", last_cap[1], w_a5);

        // Alternating pattern: fast instance must give a 2-clock sclk period.
        full_word = w_alt;
        toggle();
        wait_quiet("alt", 3000);
        check("alt_fast_cs_low", last_cs_low[1], 369);
        check("alt_fast_period_min", last_gmin[1], 2);
        check("alt_fast_period_max", last_gmax[1], 2);
        check("alt_fast_rises", last_rises[1], 184);
        check("alt_fast_bits", last_cap[1], w_alt);
        check("alt_period", {last_gmin[0], last_gmax[0]}, {32'd8, 32'd8});
        check("alt_frame_count", fc_w[0], 16'd2);

        // Second toggle while busy: back-to-back frame with the new word.
        full_word = w_a5;
        toggle();
        tick(100);
        full_word = w_one;
        toggle();
        wait_quiet("b2b", 5000);
        check("b2b_gap_dut0", last_hi_gap[0], 10);
        check("b2b_gap_dut1", last_hi_gap[1], 3);
        check("b2b_bits", last_cap[0], w_one);
        check("b2b_fast_bits", last_cap[1], w_one);
        check("b2b_frame_count", fc_w[0], 16'd4);
        check("b2b_overrun", {ov_w[0], ov_w[1]}, 2'b00);

        // Three toggles inside one frame: two frames, sticky overrun.
        full_word = w_a5;
        toggle(); tick(20);
        toggle(); tick(20);
        toggle();
        wait_quiet("ovr", 5000);
        check("ovr_frame_count", fc_w[0], 16'd6);
        check("ovr_fast_frame_count", fc_w[1], 16'd6);
        tick(200);
        check("ovr_sticky", {ov_w[0], ov_w[1]}, 2'b11);

        // Reset at rising sclk edge 90.
        full_word = w_alt;
        io_before = io_total[0];
        toggle();
        n = 0;
        while (!(rises[0] == 90 && sclk_w[0] === 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_edge90", rises[0], 90);
        rst_n = 1'b0;
        tick(1);
        check("abort_outputs", {cs_n_w[0], sclk_w[0], busy_w[0], io_w[0]}, 4'b1000);
        check("abort_frame_count", fc_w[0], 16'd0);
        tick(3);
        rst_n = 1'b1;
        tick(5);
        check("abort_no_io_update", io_total[0], io_before);
        check("abort_overrun_cleared", ov_w[0], 1'b0);
        full_word = w_a5;
        toggle();
        wait_quiet("post_abort", 3000);
        check("post_abort_rises", last_rises[0], 184);
        check("post_abort_bits", last_cap[0], w_a5);
        check("post_abort_frame_count", fc_w[0], 16'd1);

        // Random words and toggle bursts.
        for (int it = 0; it < 4; it++) begin
            for (int w = 0; w < 6; w++) tmp[w*32 +: 32] = $urandom();
            full_word = tmp[N-1:0];
            w_save = tmp[N-1:0];
            fc_prev = fc_w[0];
            n = $urandom_range(1, 3);
            for (int t = 0; t < n; t++) begin
                toggle();
                tick($urandom_range(4, 1600));
            end
            wait_quiet($sformatf("rand%0d", it), 6000);
            check($sformatf("rand%0d_bits", it), last_cap[0], w_save);
            check($sformatf("rand%0d_fast_bits", it), last_cap[1], w_save);
            check($sformatf("rand%0d_rises", it), last_rises[0], 184);
            check($sformatf("rand%0d_progress", it), (fc_w[0] > fc_prev), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
